alu_sequencer: RTL

Front-end controller for the `TotalALU` datapath. It accepts one operation at a time from a requester over a valid/ready handshake and drives the ALU's `Signal`, `dataA` and `dataB` inputs. For DIVU and MULTU it holds the op for the multi-cycle duration, then issues MFHI and MFLO automatically to collect the Hi/Lo results. It returns the result on a valid/ready response channel, so no upstream logic needs to know ALU cycle counts.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_sequencer_cycle_counter.sv | 30 +++
 rtl/alu_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the TotalALU front end: function codes, sequencer
// states and the function-code classifier.
package alu_pkg;

  // 6-bit TotalALU function codes
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RD_HI = 3'd3,
    ST_RD_LO = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CLS_SHORT = 2'd0,
    CLS_LONG  = 2'd1,
    CLS_ERR   = 2'd2
  } fn_class_t;

  // Classify a function code; MFHI/MFLO requests are ordinary short ops.
  function automatic fn_class_t fn_class(input logic [5:0] func);
    fn_class_t cls;
    case (func)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT,
      FN_SLL, FN_SRL, FN_MFHI, FN_MFLO: cls = CLS_SHORT;
      FN_MULTU, FN_DIVU:                cls = CLS_LONG;
      default:                          cls = CLS_ERR;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_sequencer_cycle_counter.sv
// Loadable down-counter that saturates at zero; done is high while the
// count is zero. A load of N gives done on the (N+1)-th edge after the load.
module cycle_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count;

  // Load has priority; otherwise count down and hold at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Front-end sequencer for TotalALU. Accepts one op over valid/ready, drives
// the ALU inputs, runs MFHI/MFLO after MULTU/DIVU and returns the result on
// a valid/ready response channel. The ALU output is registered, so every
// result is sampled one cycle after its code has been removed from the bus.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LAT     = 1,
  parameter int LONG_CYCLES = 35
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_func,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_lo,
  output logic [31:0] resp_hi,
  output logic        resp_err,
  output logic        busy,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result
);

  localparam int MAX_CYC = (LONG_CYCLES > ALU_LAT) ? LONG_CYCLES : ALU_LAT;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] LOAD_LONG = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LAT  = CNT_W'(ALU_LAT - 1);

  state_t           state;
  fn_class_t        req_cls;
  logic             is_long;
  logic             cap_hi;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // Classify the incoming request code
  always_comb begin
    req_cls = fn_class(req_func);
  end

  // Counter reload at the start of each timed phase
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (state == ST_IDLE && req_valid && req_cls != CLS_ERR) begin
      cnt_load = 1'b1;
      cnt_val  = (req_cls == CLS_LONG) ? LOAD_LONG : LOAD_LAT;
    end else if (state == ST_ISSUE && cnt_done && is_long) begin
      cnt_load = 1'b1;
      cnt_val  = LOAD_LAT;
    end else if (state == ST_RD_HI && cnt_done) begin
      cnt_load = 1'b1;
      cnt_val  = LOAD_LAT;
    end else begin
      cnt_load = 1'b0;
      cnt_val  = '0;
    end
  end

  cycle_counter #(.W(CNT_W)) u_cycle_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // Sequencer FSM with registered ALU and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      alu_signal <= FN_MFHI;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      resp_valid <= 1'b0;
      resp_lo    <= 32'd0;
      resp_hi    <= 32'd0;
      resp_err   <= 1'b0;
      is_long    <= 1'b0;
      cap_hi     <= 1'b0;
    end else begin
      // MFHI result appears on alu_result one cycle after RD_HI ends
      cap_hi <= 1'b0;
      if (cap_hi) begin
        resp_hi <= alu_result;
      end
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_cls == CLS_ERR) begin
              // Never reaches the ALU; resp_valid/resp_err rise next edge
              state <= ST_RESP;
            end else begin
              state      <= ST_ISSUE;
              alu_signal <= req_func;
              alu_a      <= req_a;
              alu_b      <= req_b;
              is_long    <= (req_cls == CLS_LONG);
            end
          end
        end
        ST_ISSUE: begin
          if (cnt_done) begin
            alu_signal <= FN_MFHI;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            state      <= is_long ? ST_RD_HI : ST_WAIT;
          end
        end
        ST_RD_HI: begin
          if (cnt_done) begin
            alu_signal <= FN_MFLO;
            cap_hi     <= 1'b1;
            state      <= ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          if (cnt_done) begin
            alu_signal <= FN_MFHI;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // One cycle for the registered ALU output, then sample it
          resp_lo    <= alu_result;
          resp_valid <= 1'b1;
          if (!is_long) begin
            resp_hi <= 32'd0;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (!resp_valid) begin
            // Only an error request enters RESP with resp_valid low
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_lo    <= 32'd0;
            resp_hi    <= 32'd0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
